div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
Iterative radix-2 divider sequencer for the RV32M DIV/DIVU/REM/REMU path in the execution stage. It accepts one operation from the execution stage and stalls that stage through hazard_x while it runs. It then returns quotient/remainder with a one-cycle div_wb writeback strobe. It owns the partial-remainder and quotient registers, the iteration counter and the sign-fixup step, and it short-circuits the RISC-V divide-by-zero and overflow corner cases.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
div_start  in  1  issue request; sampled only in IDLE.
div_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU; sampled with div_start.
dividend  in  XLEN  rs1 value; sampled with div_start.
divisor  in  XLEN  rs2 value; sampled with div_start.
kill  in  1  flush; aborts the operation in flight.
hazard_x  out  1  stall request to the execution stage.
div_wb  out  1  one-cycle result-valid / writeback strobe.
Qo  out  XLEN  quotient; held until the next accepted start.
Ro  out  XLEN  remainder; held until the next accepted start.
RSIGN  out  1  sign of the sampled dividend when div_signed=1, else 0.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; hazard_x=0, div_wb=0, Qo=0, Ro=0, RSIGN=0; counter=0. Reset mid-operation discards all work and produces no div_wb.
- Accept condition: acc = div_start & !kill & state==IDLE. div_start in any other state is ignored.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> DONE when acc and (divisor==0 or overflow). Overflow = div_signed & dividend==2^(XLEN-1) & divisor==all-ones.
- IDLE -> CALC on any other acc. On that edge: latch magnitudes |a|, |b| (signed mode, else raw values), neg_q = signed & (a_sign ^ b_sign), neg_r = signed & a_sign, partial remainder P=0, counter=XLEN-1.
- CALC, each cycle: T = {P[XLEN-1:0], A[msb]} - {1'b0, B} using an (XLEN+1)-bit subtract. If T is non-negative, P=T and q_bit=1; else P is the shifted value and q_bit=0. A shifts left, taking q_bit into its lsb. counter decrements. When counter==0, go to FIX.
- FIX: Qo = neg_q ? -Q : Q; Ro = neg_r ? -P : P; then go to DONE.
- Fast-path results (written on the acc edge):
  - divisor==0: Qo = all-ones, Ro = dividend.
  - Overflow: Qo = 2^(XLEN-1), Ro = 0.
- DONE: div_wb=1 for exactly one cycle, then IDLE. Back-to-back operation is allowed: a start arriving in the cycle after DONE (state IDLE) is accepted.
- hazard_x (combinational) = acc | state==CALC | state==FIX. It is low in DONE so the stalled instruction advances and writes back with div_wb.
- Latency, with acc at cycle t0:
  - Normal: CALC occupies t0+1 through t0+XLEN, FIX is t0+XLEN+1, div_wb is high at t0+XLEN+2 (34 cycles for XLEN=32).
  - Fast path: div_wb is high at t0+1.
- kill:
  - In CALC or FIX: next state is IDLE, hazard_x drops the next cycle, no div_wb, and Qo/Ro keep their prior values.
  - In IDLE, kill suppresses acc.
  - In DONE, kill has no effect (the strobe still fires; the pipeline qualifies it).
- RSIGN: updated on acc, held until the next acc.
- Width rules: all negation is two's complement modulo 2^XLEN. Magnitude of 2^(XLEN-1) is taken as unsigned 2^(XLEN-1), which is correct for divisors other than -1.

Decomposition:
- Shared instruction_pkg: div_state_e enum (IDLE, CALC, FIX, DONE) and the function codes DIV, DIVU, REM, REMU.
- One combinational sub-module, div_step: inputs P, A msb, B; outputs the next P and q_bit. It is instantiated once per cycle (radix-2), so it can later be widened to radix-4 by instantiating it twice.

Test Plan:
- DIVU 20/3, div_signed=0 -> hazard_x high for cycles t0..t0+33; div_wb at t0+34 with Qo=6, Ro=2, RSIGN=0.
- DIV -7/2, div_signed=1 -> Qo=0xFFFFFFFD, Ro=0xFFFFFFFF, RSIGN=1 at t0+34. Also 7/-2 -> Qo=0xFFFFFFFD, Ro=1.
- Divide by zero: 0x12345678/0 -> div_wb at t0+1 with Qo=0xFFFFFFFF, Ro=0x12345678; hazard_x high only at t0.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> div_wb at t0+1 with Qo=0x80000000, Ro=0. The same operands unsigned take 34 cycles and give Qo=0, Ro=0x80000000.
- kill at t0+10 -> hazard_x low from t0+11, no div_wb, Qo/Ro unchanged. A new start (100/7) at t0+12 gives Qo=14, Ro=2 at t0+46. A start asserted during CALC is ignored.
- Reset pulsed low at t0+5, asynchronously between clock edges -> outputs go to 0 immediately and no div_wb occurs. A start after reset is released completes normally.

Source files
------------

// File: rtl/instruction_pkg.sv
// ---------------------------------------------------------------------------
// instruction_pkg
// Shared definitions for the execution-stage M-extension divide path.
//   div_state_e  : sequencer states of the iterative divider
//   DIV..REMU    : funct3 codes of the RV32M divide/remainder instructions
//   XLEN_DEFAULT : default datapath width
// No ports (package).
// ---------------------------------------------------------------------------
package instruction_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // funct3 encodings of the divide family (OP opcode, funct7 = 0000001)
  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

endpackage

// File: rtl/div_ctrl_step.sv
// ---------------------------------------------------------------------------
// div_ctrl_step
// One radix-2 restoring-division step, purely combinational.
// Ports:
//   p       in  XLEN  current partial remainder (always < b)
//   a_msb   in  1     next dividend bit shifted into the partial remainder
//   b       in  XLEN  divisor magnitude
//   next_p  out XLEN  partial remainder after this step
//   q_bit   out 1     quotient bit produced by this step
// Instantiating two of these back to back gives a radix-4 step.
// ---------------------------------------------------------------------------
module div_ctrl_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] p,
  input  logic            a_msb,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] next_p,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  assign shifted = {p, a_msb};

  // The trial subtraction succeeds when the shifted remainder is at least b.
  // Because p < b, a successful difference always fits in XLEN bits, so the
  // low-order subtract below is exact and the top bit of shifted only matters
  // for the comparison.
  assign q_bit  = (shifted >= {1'b0, b});
  assign next_p = q_bit ? (shifted[XLEN-1:0] - b) : shifted[XLEN-1:0];

endmodule

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Iterative radix-2 divider sequencer for RV32M DIV/DIVU/REM/REMU. Accepts one
// operation from the execution stage, stalls it through hazard_x while the
// XLEN iterations and the sign fixup run, then pulses div_wb for one cycle.
// Divide-by-zero and signed overflow are answered directly without iterating.
// Ports:
//   clk        in  1     clock, rising edge
//   reset      in  1     asynchronous active-low reset
//   div_start  in  1     issue request, only honoured in IDLE
//   div_signed in  1     1 = DIV/REM, 0 = DIVU/REMU
//   dividend   in  XLEN  rs1 value
//   divisor    in  XLEN  rs2 value
//   kill       in  1     flush of the operation in flight
//   hazard_x   out 1     stall request to the execution stage
//   div_wb     out 1     one-cycle result-valid strobe
//   Qo         out XLEN  quotient, held until the next accepted start
//   Ro         out XLEN  remainder, held until the next accepted start
//   RSIGN      out 1     sign of the accepted dividend in signed mode
// ---------------------------------------------------------------------------
module div_ctrl
  import instruction_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_start,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            hazard_x,
  output logic            div_wb,
  output logic [XLEN-1:0] Qo,
  output logic [XLEN-1:0] Ro,
  output logic            RSIGN
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state, state_next;

  logic [XLEN-1:0]  a_reg;
  logic [XLEN-1:0]  b_reg;
  logic [XLEN-1:0]  p_reg;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] counter;

  logic            acc;
  logic            dividend_neg;
  logic            divisor_neg;
  logic            div_by_zero;
  logic            overflow;
  logic            fast_path;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] step_p;
  logic            step_q;

  assign acc          = div_start & ~kill & (state == IDLE);
  assign dividend_neg = div_signed & dividend[XLEN-1];
  assign divisor_neg  = div_signed & divisor[XLEN-1];
  assign div_by_zero  = (divisor == '0);
  assign overflow     = div_signed & (dividend == MIN_INT) & (&divisor);
  assign fast_path    = div_by_zero | overflow;

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed here.
  assign a_mag = dividend_neg ? -dividend : dividend;
  assign b_mag = divisor_neg  ? -divisor  : divisor;

  div_ctrl_step #(
    .XLEN(XLEN)
  ) u_step (
    .p     (p_reg),
    .a_msb (a_reg[XLEN-1]),
    .b     (b_reg),
    .next_p(step_p),
    .q_bit (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The counter reaches zero on the last of the XLEN
  // iterations; kill only aborts the CALC and FIX states.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (acc) begin
          state_next = fast_path ? DONE : CALC;
        end
      end
      CALC: begin
        if (kill) begin
          state_next = IDLE;
        end else if (counter == '0) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = kill ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. hazard_x covers the accept cycle itself so the issuing
  // instruction is held immediately; it drops in DONE so that instruction
  // advances alongside div_wb.
  always_comb begin
    hazard_x = acc | (state == CALC) | (state == FIX);
    div_wb   = (state == DONE);
  end

  // Datapath. The dividend register doubles as the quotient register: each
  // step shifts one dividend bit out of the top and one quotient bit into the
  // bottom. Qo/Ro are only written on a fast-path accept or in FIX, so a
  // killed operation leaves the previous result visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      p_reg   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      counter <= '0;
      Qo      <= '0;
      Ro      <= '0;
      RSIGN   <= 1'b0;
    end else begin
      if (acc) begin
        RSIGN <= dividend_neg;
        if (div_by_zero) begin
          Qo <= '1;
          Ro <= dividend;
        end else if (overflow) begin
          Qo <= MIN_INT;
          Ro <= '0;
        end else begin
          a_reg   <= a_mag;
          b_reg   <= b_mag;
          p_reg   <= '0;
          neg_q   <= dividend_neg ^ divisor_neg;
          neg_r   <= dividend_neg;
          counter <= CNT_W'(XLEN - 1);
        end
      end else if ((state == CALC) && !kill) begin
        p_reg   <= step_p;
        a_reg   <= {a_reg[XLEN-2:0], step_q};
        counter <= counter - CNT_W'(1);
      end else if ((state == FIX) && !kill) begin
        Qo <= neg_q ? -a_reg : a_reg;
        Ro <= neg_r ? -p_reg : p_reg;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl: directed corner cases followed by random
// operations, compared against a reference built from the RISC-V division
// rules using plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_div_ctrl;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            div_start;
  logic            div_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            kill;
  logic            hazard_x;
  logic            div_wb;
  logic [XLEN-1:0] Qo;
  logic [XLEN-1:0] Ro;
  logic            RSIGN;

  int check_count;
  int fail_count;

  logic [XLEN-1:0] last_q;
  logic [XLEN-1:0] last_r;
  logic            last_s;

  div_ctrl #(
    .XLEN(XLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .div_signed(div_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .kill      (kill),
    .hazard_x  (hazard_x),
    .div_wb    (div_wb),
    .Qo        (Qo),
    .Ro        (Ro),
    .RSIGN     (RSIGN)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: RISC-V division semantics plus the expected strobe latency.
  function automatic void refDivide(input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b,
                                    input logic sgn,
                                    output logic [XLEN-1:0] q,
                                    output logic [XLEN-1:0] r,
                                    output int lat);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q   = '1;
      r   = a;
      lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q   = 32'h8000_0000;
      r   = '0;
      lat = 1;
    end else begin
      lat = XLEN + 2;
      if (sgn) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation in the current cycle and follows it to its strobe.
  // noise: throw ignored starts at the busy divider.
  // kill_done: assert kill in the strobe cycle, which must not suppress it.
  task automatic applyStimulus(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic sgn, input bit noise, input bit kill_done);
    logic [XLEN-1:0] eq;
    logic [XLEN-1:0] er;
    logic            es;
    int              lat;
    int              k;
    int              hz;
    bit              seen;
    refDivide(a, b, sgn, eq, er, lat);
    es = sgn & a[XLEN-1];
    div_start  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    kill       = 1'b0;
    #1;
    checkOutput("hazard_t0", 64'(hazard_x), 64'(1));
    k    = 0;
    hz   = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      tick();
      k++;
      div_start = 1'b0;
      kill      = kill_done && (k == lat);
      if (noise && k < lat && $urandom_range(0, 2) == 0) begin
        div_start  = 1'b1;
        div_signed = 1'($urandom_range(0, 1));
        dividend   = $urandom;
        divisor    = $urandom;
      end
      #1;
      if (div_wb) seen = 1'b1;
      else if (hazard_x) hz++;
    end
    checkOutput("latency", 64'(k), 64'(lat));
    checkOutput("hazard_cycles", 64'(hz), 64'(lat - 1));
    checkOutput("hazard_at_wb", 64'(hazard_x), 64'(0));
    checkOutput("quotient", 64'(Qo), 64'(eq));
    checkOutput("remainder", 64'(Ro), 64'(er));
    checkOutput("rsign", 64'(RSIGN), 64'(es));
    tick();
    div_start = 1'b0;
    kill      = 1'b0;
    #1;
    checkOutput("wb_one_cycle", 64'(div_wb), 64'(0));
    checkOutput("quotient_held", 64'(Qo), 64'(eq));
    checkOutput("remainder_held", 64'(Ro), 64'(er));
    last_q = eq;
    last_r = er;
    last_s = es;
  endtask

  // Starts an operation and flushes it kill_k cycles later; ends two cycles
  // after the kill so the next start lands at t0 + kill_k + 2.
  task automatic killStimulus(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic sgn, input int kill_k);
    bit wb_seen;
    wb_seen    = 1'b0;
    div_start  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    kill       = 1'b0;
    #1;
    checkOutput("kill_hazard_t0", 64'(hazard_x), 64'(1));
    for (int k = 1; k <= kill_k; k++) begin
      tick();
      div_start = (k == 3);
      kill      = (k == kill_k);
      #1;
      if (div_wb) wb_seen = 1'b1;
    end
    checkOutput("kill_hazard_same", 64'(hazard_x), 64'(1));
    tick();
    div_start = 1'b0;
    kill      = 1'b0;
    #1;
    if (div_wb) wb_seen = 1'b1;
    checkOutput("kill_hazard_next", 64'(hazard_x), 64'(0));
    checkOutput("kill_q_held", 64'(Qo), 64'(last_q));
    checkOutput("kill_r_held", 64'(Ro), 64'(last_r));
    checkOutput("kill_rsign", 64'(RSIGN), 64'(sgn & a[XLEN-1]));
    last_s = sgn & a[XLEN-1];
    tick();
    #1;
    if (div_wb) wb_seen = 1'b1;
    checkOutput("kill_no_wb", 64'(wb_seen), 64'(0));
  endtask

  // A start with kill in IDLE must not be accepted; divisor 0 would
  // otherwise strobe on the very next cycle.
  task automatic idleKillStimulus();
    bit wb_seen;
    wb_seen    = 1'b0;
    div_start  = 1'b1;
    kill       = 1'b1;
    div_signed = 1'b1;
    dividend   = 32'hF000_0005;
    divisor    = '0;
    #1;
    checkOutput("idle_kill_hazard", 64'(hazard_x), 64'(0));
    tick();
    div_start = 1'b0;
    kill      = 1'b0;
    #1;
    checkOutput("idle_kill_no_wb", 64'(div_wb), 64'(0));
    checkOutput("idle_kill_q_held", 64'(Qo), 64'(last_q));
    checkOutput("idle_kill_rsign", 64'(RSIGN), 64'(last_s));
    for (int k = 0; k < 40; k++) begin
      tick();
      #1;
      if (div_wb) wb_seen = 1'b1;
    end
    checkOutput("idle_kill_quiet", 64'(wb_seen), 64'(0));
  endtask

  // Asynchronous reset in the middle of an operation.
  task automatic resetStimulus();
    bit wb_seen;
    wb_seen    = 1'b0;
    div_start  = 1'b1;
    div_signed = 1'b1;
    dividend   = 32'hFFFF_F000;
    divisor    = 32'd3;
    #1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      div_start = 1'b0;
    end
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_hazard", 64'(hazard_x), 64'(0));
    checkOutput("rst_mid_wb", 64'(div_wb), 64'(0));
    checkOutput("rst_mid_q", 64'(Qo), 64'(0));
    checkOutput("rst_mid_r", 64'(Ro), 64'(0));
    checkOutput("rst_mid_rsign", 64'(RSIGN), 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      #1;
      if (div_wb) wb_seen = 1'b1;
    end
    checkOutput("rst_no_wb", 64'(wb_seen), 64'(0));
    checkOutput("rst_q_stays", 64'(Qo), 64'(0));
    last_q = '0;
    last_r = '0;
    last_s = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    check_count = 0;
    fail_count  = 0;
    last_q      = '0;
    last_r      = '0;
    last_s      = 1'b0;
    reset       = 1'b0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    dividend    = '0;
    divisor     = '0;
    kill        = 1'b0;

    #12;
    checkOutput("rst_hazard", 64'(hazard_x), 64'(0));
    checkOutput("rst_wb", 64'(div_wb), 64'(0));
    checkOutput("rst_q", 64'(Qo), 64'(0));
    checkOutput("rst_r", 64'(Ro), 64'(0));
    checkOutput("rst_rsign", 64'(RSIGN), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("[TB] directed operations");
    applyStimulus(32'd20, 32'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    $display("[TB] kill handling");
    killStimulus(32'hFFFF_FF9C, 32'd3, 1'b1, 10);
    applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    killStimulus(32'd999, 32'd10, 1'b0, 33);
    idleKillStimulus();
    applyStimulus(32'hFFFF_FF00, 32'd7, 1'b1, 1'b0, 1'b1);

    $display("[TB] asynchronous reset");
    resetStimulus();
    applyStimulus(32'd12345, 32'd100, 1'b0, 1'b0, 1'b0);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: ;
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
